// File: rtl/mod_n_down_counter.sv
// Synchronous modulo-N down counter (N-1 -> 0 -> N-1) with clamped load, enable and cascadable borrow.
// Define MODN_DIVOUT_EN to add div_o, a divide-by-2N output toggled on each borrow.
module mod_n_down_counter #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q,
    output logic         tc,
    output logic         borrow
`ifdef MODN_DIVOUT_EN
    ,
    output logic         div_o
`endif
);

    localparam logic [W-1:0] TOP = W'(N - 1);

    function automatic logic [W-1:0] clamp_load(input logic [W-1:0] v);
        return (v > TOP) ? TOP : v;
    endfunction

    // Zero wraps to TOP; an upset value above TOP is also pulled back to TOP.
    function automatic logic [W-1:0] dec_wrap(input logic [W-1:0] v);
        return ((v == '0) || (v > TOP)) ? TOP : v - W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= TOP;
        end else if (load) begin
            q <= clamp_load(load_val);
        end else if (en) begin
            q <= dec_wrap(q);
        end
    end

    assign tc     = (q == '0);
    assign borrow = tc & en;

`ifdef MODN_DIVOUT_EN
    // Toggles once per full count cycle, giving a 50% duty output at f_clk/(2N) with en high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_o <= 1'b0;
        end else if (borrow && !load) begin
            div_o <= ~div_o;
        end
    end
`endif

endmodule

// File: tb/tb_mod_n_down_counter.sv
// Scoreboard bench for mod_n_down_counter: directed stimulus pushes expectations, a negedge monitor checks them.
// Two chained N=5 stages; div_o checks are active when MODN_DIVOUT_EN is defined.
module tb_mod_n_down_counter;

    typedef struct {
        int       tag;
        logic [2:0] q;
        logic     tc;
        logic     b;
        logic     chk_hi;
        logic [2:0] hi_q;
        logic     hi_tc;
        logic     hi_b;
        logic     chk_div;
        logic     div;
        logic     hi_div;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [2:0] load_val;
    logic [2:0] q;
    logic       tc;
    logic       borrow;
    logic [2:0] hi_q;
    logic       hi_tc;
    logic       hi_b;
`ifdef MODN_DIVOUT_EN
    logic       div_o;
    logic       hi_div;
`endif

    exp_t sbq[$];
    exp_t e_m;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tc_seen = 0;
    logic [2:0] seq [5] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    always #5 clk = ~clk;

    mod_n_down_counter #(.N(5), .W(3)) u_lo (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .q(q), .tc(tc), .borrow(borrow)
`ifdef MODN_DIVOUT_EN
        , .div_o(div_o)
`endif
    );

    mod_n_down_counter #(.N(5), .W(3)) u_hi (
        .clk(clk), .rst(rst), .en(borrow), .load(1'b0), .load_val(3'd0),
        .q(hi_q), .tc(hi_tc), .borrow(hi_b)
`ifdef MODN_DIVOUT_EN
        , .div_o(hi_div)
`endif
    );

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (tag %0d) at %0t: got %0d, want %0d", nm, tag, $time, act, exp);
        end
    endtask

    function automatic exp_t mk(input int tag, input logic [2:0] eq, input logic etc, input logic eb,
                                input logic cd = 1'b0, input logic ed = 1'b0);
        exp_t x;
        x.tag = tag; x.q = eq; x.tc = etc; x.b = eb;
        x.chk_hi = 1'b0; x.hi_q = '0; x.hi_tc = 1'b0; x.hi_b = 1'b0;
        x.chk_div = cd; x.div = ed; x.hi_div = 1'b0;
        return x;
    endfunction

    // Cascade row j: lower stage runs the 4..0 table, upper stage steps once per five rows.
    function automatic exp_t mkc(input int j);
        exp_t x;
        x = mk(7, seq[j % 5], (j % 5) == 4, (j % 5) == 4, 1'b1, ((j / 5) % 2) == 1);
        x.chk_hi = 1'b1;
        x.hi_q   = seq[(j / 5) % 5];
        x.hi_tc  = ((j / 5) % 5) == 4;
        x.hi_b   = (((j / 5) % 5) == 4) && ((j % 5) == 4);
        x.hi_div = (j >= 25);
        return x;
    endfunction

    // Inputs change 1 time unit after the rising edge; the expectation describes what the
    // monitor sees at the following falling edge (q from the previous edge, borrow from the new en).
    task automatic cyc(input logic r, input logic e, input logic l, input logic [2:0] lv, input exp_t x);
        @(posedge clk);
        #1;
        rst = r; en = e; load = l; load_val = lv;
        sbq.push_back(x);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            e_m = sbq.pop_front();
            chk("q", e_m.tag, 32'(q), 32'(e_m.q));
            chk("tc", e_m.tag, 32'(tc), 32'(e_m.tc));
            chk("borrow", e_m.tag, 32'(borrow), 32'(e_m.b));
            if (e_m.tag == 2 && tc === 1'b1) tc_seen++;
            if (e_m.chk_hi) begin
                chk("hi_q", e_m.tag, 32'(hi_q), 32'(e_m.hi_q));
                chk("hi_tc", e_m.tag, 32'(hi_tc), 32'(e_m.hi_tc));
                chk("hi_borrow", e_m.tag, 32'(hi_b), 32'(e_m.hi_b));
            end
`ifdef MODN_DIVOUT_EN
            if (e_m.chk_div) begin
                chk("div_o", e_m.tag, 32'(div_o), 32'(e_m.div));
                if (e_m.chk_hi) chk("hi_div_o", e_m.tag, 32'(hi_div), 32'(e_m.hi_div));
            end
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en = 1'b1; load = 1'b0; load_val = 3'd0;
        // reset held with en high, then release and count down
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 3'd0, mk(1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0));
        cyc(1'b1, 1'b1, 1'b0, 3'd0, mk(1, 3'd4, 1'b0, 1'b0));
        cyc(1'b1, 1'b1, 1'b0, 3'd0, mk(1, 3'd3, 1'b0, 1'b0));
        cyc(1'b1, 1'b1, 1'b0, 3'd0, mk(1, 3'd2, 1'b0, 1'b0));
        cyc(1'b1, 1'b1, 1'b0, 3'd0, mk(1, 3'd1, 1'b0, 1'b0));
        cyc(1'b1, 1'b1, 1'b0, 3'd0, mk(1, 3'd0, 1'b1, 1'b1));
        // 20 enabled cycles: 4,3,2,1,0 four times
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 1'b1, 1'b0, 3'd0, mk(2, seq[i % 5], (i % 5) == 4, (i % 5) == 4));
        // load beats en; out-of-range load clamps to 4
        cyc(1'b1, 1'b1, 1'b1, 3'd2, mk(3, 3'd4, 1'b0, 1'b0));
        cyc(1'b1, 1'b1, 1'b1, 3'd7, mk(3, 3'd2, 1'b0, 1'b0));
        cyc(1'b1, 1'b0, 1'b1, 3'd3, mk(3, 3'd4, 1'b0, 1'b0));
        // enable gating 1,0,0,1 from q=3
        cyc(1'b1, 1'b1, 1'b0, 3'd0, mk(4, 3'd3, 1'b0, 1'b0));
        cyc(1'b1, 1'b0, 1'b0, 3'd0, mk(4, 3'd2, 1'b0, 1'b0));
        cyc(1'b1, 1'b0, 1'b0, 3'd0, mk(4, 3'd2, 1'b0, 1'b0));
        cyc(1'b1, 1'b1, 1'b0, 3'd0, mk(4, 3'd2, 1'b0, 1'b0));
        cyc(1'b1, 1'b1, 1'b0, 3'd0, mk(4, 3'd1, 1'b0, 1'b0));
        // load at q=0 with en=1: borrow still high, no wrap
        cyc(1'b1, 1'b1, 1'b1, 3'd1, mk(5, 3'd0, 1'b1, 1'b1));
        cyc(1'b1, 1'b0, 1'b0, 3'd0, mk(5, 3'd1, 1'b0, 1'b0));
        // asynchronous reset between edges at q=1
        cyc(1'b0, 1'b1, 1'b0, 3'd0, mk(6, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0));
        // two-stage cascade for 50 cycles
        for (int j = 0; j < 50; j++)
            cyc(1'b1, 1'b1, 1'b0, 3'd0, mkc(j));
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 0, 32'(sbq.size()), 32'd0);
        chk("tc_high_count", 2, 32'(tc_seen), 32'd4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod_n_down_counter.md
# mod_n_down_counter

Synchronous, parameterised modulo-N down counter: the count-down counterpart of the team's mod-5 up counter. It counts N-1 → 0 and then wraps to N-1. It supports parallel load, count enable and a cascadable borrow output. It replaces ripple-clocked T-flop chains in timers and clock-enable generators: every flop sits on the single `clk` domain, so there are no derived clocks.

## Interface
Parameters:
- `N`, default 5: modulus; legal range 2..2^W.
- `W`, default 3: counter width; must satisfy 2^W ≥ N.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: count enable; decrement by one when high.
- `load` in 1: synchronous parallel load.
- `load_val` in W: value captured on `load`.
- `q` out W: current count, registered.
- `tc` out 1: terminal count; combinational, `q == 0`.
- `borrow` out 1: combinational `tc & en`; drives `en` of the next, more-significant stage.
- `div_o` out 1: divided output; present only with `MODN_DIVOUT_EN`.

## Operation
- Reset (`rst` low, asynchronous):
  - `q` = N-1, `tc` = 0, `borrow` = 0, `div_o` = 0.
  - Holds for as long as `rst` is low, and overrides any cycle in progress.
- Priority on each rising edge: `load` > `en` > hold.
- Load:
  - `q` ← `load_val` if `load_val` ≤ N-1.
  - Otherwise `q` ← N-1 (clamp).
  - `en` is ignored in the load cycle.
- Count with `en`=1 and `load`=0:
  - `q` ← `q`-1 while `q` > 0.
  - `q` ← N-1 when `q` == 0 (wrap).
- Hold with `en`=0 and `load`=0: `q` unchanged.
- Illegal state (`q` > N-1, reachable only by upset):
  - Next enabled count cycle forces `q` ← N-1.
  - `tc` = 0 while illegal.
- Sequence, N=5, `en` held high: 4,3,2,1,0,4,...
  - `tc` is high for 1 of every N enabled cycles.
- Cascade: stage k+1 `en` = stage k `borrow`.
  - Two chained N=5 stages give mod-25.
  - All stages stay synchronous to `clk`.
- N = 2^W: wrap equals natural underflow; the clamp is never active.

## Timing
- `q` updates one cycle after `load` or `en` is sampled. Latency from load to `q` is 1 clock.
- `tc` and `borrow` are purely combinational from `q` and `en`: same-cycle, no register delay.
- Reset assertion:
  - Asynchronous; `q` = N-1 with no clock needed.
  - Deassertion is synchronised externally; the first count occurs on the first edge with `rst` high.
- Load on a cycle where `q` == 0 with `en`=1: load wins, no wrap occurs, and `borrow` is still 1 during that cycle (combinational).
- No combinational path from `load`/`load_val` to any output.

## Configuration
- Macro `MODN_DIVOUT_EN`.
- Defined:
  - Adds port `div_o`, a register that toggles on every cycle where `borrow` = 1 and `load` = 0.
  - With `en` tied high, `div_o` is a 50% duty clock at f_clk/(2N).
  - `div_o` reset value is 0; `load` does not change `div_o`.
- Undefined:
  - Port `div_o` and its register are absent.
  - All other behaviour is identical.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `en`=1 → `q`=4, `tc`=0 throughout. Release → `q` = 3,2,1,0,4 on successive edges.
- Wrap/tc (N=5, `en`=1, 20 cycles) → `tc` high exactly 4 times, each time with `q`=0. `borrow` matches `tc`.
- Load priority:
  - `load`=1, `load_val`=2, `en`=1 in the same cycle → `q`=2 next cycle.
  - `load_val`=7 → `q`=4 (clamp).
- Enable gating: `en` toggled 1,0,0,1 from `q`=3 → `q` = 2,2,2,1.
- Async reset mid-count: assert `rst` low between edges at `q`=1 → `q`=4 immediately. Also `div_o`=0 with `MODN_DIVOUT_EN`.
- Cascade + divider (`MODN_DIVOUT_EN`): two stages chained, `en`=1 for 50 cycles → upper stage decrements once per 5 clocks. Lower stage `div_o` period is 10 clocks, high 5 / low 5.
